// File: rtl/vscale_hasti_dma.sv
// vscale_hasti_dma: single-beat HASTI master that copies cfg_len words from cfg_src to cfg_dst.
module vscale_hasti_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 cfg_start,
    input  logic [31:0]          cfg_src,
    input  logic [31:0]          cfg_dst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          haddr,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    output logic                 hmastlock,
    output logic [3:0]           hprot,
    output logic [1:0]           htrans,
    output logic [31:0]          hwdata,
    input  logic [31:0]          hrdata,
    input  logic                 hready,
    input  logic                 hresp
);
    typedef enum logic [2:0] {IDLE, RA, RD, WA, WD, FIN} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d, data_q, data_d, haddr_q, haddr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 err_q, err_d, hwrite_q, hwrite_d;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            data_q   <= '0;
            haddr_q  <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            hwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
            haddr_q  <= haddr_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            hwrite_q <= hwrite_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        data_d   = data_q;
        haddr_d  = haddr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        hwrite_d = hwrite_q;
        case (state_q)
            IDLE: if (cfg_start) begin
                src_d   = cfg_src & ~32'h3;
                dst_d   = cfg_dst & ~32'h3;
                rem_d   = cfg_len;
                err_d   = 1'b0;
                state_d = (cfg_len != '0) ? RA : FIN;
            end
            RA: begin
                haddr_d  = src_q;
                hwrite_d = 1'b0;
                state_d  = hready ? RD : RA;
            end
            RD: if (hready) begin
                err_d   = hresp;
                data_d  = hresp ? data_q : hrdata;
                state_d = hresp ? FIN : WA;
            end
            WA: begin
                haddr_d  = dst_q;
                hwrite_d = 1'b1;
                state_d  = hready ? WD : WA;
            end
            WD: if (hready) begin
                if (hresp) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? FIN : RA;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address-phase outputs are live in RA/WA and otherwise hold the last issued transfer.
    assign haddr     = (state_q == RA) ? src_q : (state_q == WA) ? dst_q : haddr_q;
    assign hwrite    = (state_q == RA) ? 1'b0 : (state_q == WA) ? 1'b1 : hwrite_q;
    assign htrans    = (state_q == RA || state_q == WA) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwdata    = data_q;
    assign hsize     = 3'd2;
    assign hburst    = 3'd0;
    assign hmastlock = 1'b0;
    assign hprot     = 4'b0011;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;
endmodule

// File: tb/tb_vscale_hasti_dma.sv
// tb_vscale_hasti_dma: table-driven copies against a modelled HASTI slave with a transfer scoreboard.
module tb_vscale_hasti_dma;
    logic        hclk = 1'b0, hreset = 1'b1, cfg_start = 1'b0;
    logic [31:0] cfg_src = '0, cfg_dst = '0, hrdata = '0;
    logic [15:0] cfg_len = '0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic        busy, done, err, hwrite, hmastlock;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    vscale_hasti_dma #(.LEN_WIDTH(16)) dut (
        .hclk(hclk), .hreset(hreset), .cfg_start(cfg_start), .cfg_src(cfg_src),
        .cfg_dst(cfg_dst), .cfg_len(cfg_len), .busy(busy), .done(done), .err(err),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] src, dst;
        logic [15:0] len;
        int w, aw, erd, done_at;
        logic err;
    } vec_t;
    typedef struct { logic [31:0] a, d; } wr_t;

    int checks = 0, errors = 0, cyc = 0, t0 = 0;
    int wait_n = 0, aw_n = 0, err_rd = -1, rd_cnt = 0, wc = 0, awc = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    wr_t         wr_q [$];
    logic        dp_v = 1'b0, dp_w = 1'b0, hold_v = 1'b0;
    logic [31:0] dp_a = '0, hold_a = '0;
    vec_t        vt [7];

    always @(posedge hclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, expected none (t=%0t)", name, $time);
    endtask

    // Slave model: decides hready/hresp/hrdata for the current cycle and scores completed transfers.
    always @(negedge hclk) begin
        wr_t w;
        if (hreset) begin
            dp_v = 1'b0; hold_v = 1'b0; awc = 0;
            hready = 1'b1; hresp = 1'b0;
        end else begin
            if (hold_v) begin
                chk("addr_hold", haddr, hold_a);
                chk("trans_hold", {30'd0, htrans}, 32'd2);
                hold_v = 1'b0;
            end
            hready = 1'b1;
            hresp  = 1'b0;
            if (dp_v) begin
                if (dp_w && wr_q.size() > 0) chk("hwdata_stable", hwdata, wr_q[0].d);
                if (wc < wait_n) begin
                    hready = 1'b0;
                    hrdata = $urandom;
                    wc++;
                end else if (!dp_w) begin
                    hrdata = mem.exists(dp_a) ? mem[dp_a] : 32'h0;
                    hresp  = (rd_cnt == err_rd);
                    rd_cnt++;
                end else if (wr_q.size() == 0) begin
                    fail("extra_write");
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", dp_a, w.a);
                    chk("wr_data", hwdata, w.d);
                end
            end else if (htrans == 2'b10 && awc < aw_n) begin
                hready = 1'b0;
                awc++;
                hold_v = 1'b1;
                hold_a = haddr;
            end
            if (hready) begin
                dp_v = 1'b0;
                if (htrans == 2'b10) begin
                    awc = 0; wc = 0;
                    dp_v = 1'b1; dp_a = haddr; dp_w = hwrite;
                    if (!hwrite) begin
                        if (rd_q.size() == 0) fail("extra_read");
                        else chk("rd_addr", haddr, rd_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic start(input vec_t v);
        logic [31:0] s, d, x;
        @(negedge hclk);
        wait_n = v.w; aw_n = v.aw; err_rd = v.erd; rd_cnt = 0;
        s = v.src & ~32'h3;
        d = v.dst & ~32'h3;
        for (int i = 0; i < int'(v.len); i++) begin
            x = $urandom;
            mem[s + 32'(4 * i)] = x;
            if (v.erd < 0 || i <= v.erd) rd_q.push_back(s + 32'(4 * i));
            if (v.erd < 0 || i < v.erd) wr_q.push_back('{d + 32'(4 * i), x});
        end
        cfg_src = v.src; cfg_dst = v.dst; cfg_len = v.len;
        cfg_start = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_done(input vec_t v, input int poke);
        bit found = 0;
        @(negedge hclk);
        cfg_start = 1'b0;
        chk("busy_c1", {31'd0, busy}, 32'd1);
        chk("htrans_c1", {30'd0, htrans}, (v.len != 0) ? 32'd2 : 32'd0);
        if (v.len != 0) chk("haddr_c1", haddr, v.src & ~32'h3);
        for (int k = 0; k < 400 && !found; k++) begin
            if (done) found = 1;
            else begin
                @(negedge hclk);
                cfg_start = ((cyc - t0) == poke);
                if (cfg_start) begin
                    cfg_src = 32'h900; cfg_dst = 32'hA00; cfg_len = 16'd5;
                end
            end
        end
        cfg_start = 1'b0;
        if (!found) fail("done_timeout");
        else begin
            chk("done_cycle", 32'(cyc - t0), 32'(v.done_at));
            chk("err_at_done", {31'd0, err}, {31'd0, v.err});
        end
        @(negedge hclk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("rd_left", 32'(rd_q.size()), 32'd0);
        chk("wr_left", 32'(wr_q.size()), 32'd0);
        @(negedge hclk);
        chk("htrans_idle", {30'd0, htrans}, 32'd0);
        chk("err_sticky", {31'd0, err}, {31'd0, v.err});
    endtask

    initial begin
        vec_t v;
        vt[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 0, -1, 13, 1'b0};
        vt[1] = '{32'h0000_0100, 32'h0000_0400, 16'd1, 2, 0, -1,  9, 1'b0};
        vt[2] = '{32'h0000_0100, 32'h0000_0200, 16'd0, 0, 0, -1,  1, 1'b0};
        vt[3] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 0, 0,  1,  7, 1'b1};
        vt[4] = '{32'hFFFF_FFFC, 32'h0000_0300, 16'd2, 0, 0, -1,  9, 1'b0};
        vt[5] = '{32'h0000_0103, 32'h0000_0500, 16'd2, 1, 0, -1, 13, 1'b0};
        vt[6] = '{32'h0000_0800, 32'h0000_0C00, 16'd1, 0, 1, -1,  7, 1'b0};

        // cfg_start held alongside reset must not launch a copy
        cfg_start = 1'b1; cfg_len = 16'd2; cfg_src = 32'h40;
        repeat (3) @(negedge hclk);
        #1 hreset = 1'b0; cfg_start = 1'b0;
        @(negedge hclk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("hsize", {29'd0, hsize}, 32'd2);
        chk("hburst", {29'd0, hburst}, 32'd0);
        chk("hmastlock", {31'd0, hmastlock}, 32'd0);
        chk("hprot", {28'd0, hprot}, 32'd3);

        for (int i = 0; i < 7; i++) begin
            start(vt[i]);
            wait_done(vt[i], -1);
        end

        // a second cfg_start mid-copy must leave the running copy untouched
        v = '{32'h0000_0100, 32'h0000_0700, 16'd2, 0, 0, -1, 9, 1'b0};
        start(v);
        wait_done(v, 3);

        // reset during the word-2 write address phase
        v = '{32'h0000_0100, 32'h0000_0600, 16'd3, 0, 0, -1, 13, 1'b0};
        start(v);
        @(negedge hclk);
        cfg_start = 1'b0;
        repeat (6) @(negedge hclk);
        chk("wa2_htrans", {30'd0, htrans}, 32'd2);
        chk("wa2_hwrite", {31'd0, hwrite}, 32'd1);
        chk("wa2_haddr", haddr, 32'h604);
        #1 hreset = 1'b1;
        @(negedge hclk);
        chk("mid_rst_htrans", {30'd0, htrans}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_haddr", haddr, 32'd0);
        chk("mid_rst_hwdata", hwdata, 32'd0);
        chk("mid_rst_hwrite", {31'd0, hwrite}, 32'd0);
        rd_q.delete();
        wr_q.delete();
        #1 hreset = 1'b0;
        v = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 0, -1, 13, 1'b0};
        start(v);
        wait_done(v, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
